// File: rtl/term_ctrl.sv
// Terminal controller: turns a UART byte stream into text-buffer cell writes, with
// cursor tracking, ANSI CSI parsing, per-row line lengths and an input byte FIFO.
module term_ctrl #(
    parameter int COLS       = 80,
    parameter int ROWS       = 60,
    parameter int ADDR_W     = 13,
    parameter int FIFO_DEPTH = 4,
    parameter int WRAP_MODE  = 0,
    parameter int SHOW_LEN   = 1,
    parameter int LEN_DIGITS = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [ADDR_W-1:0] cursor,
    output logic [6:0]        cur_len,
    output logic              busy,
    output logic              ovf
);
    localparam int FA = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] COLS_A     = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] CELLS_LAST = ADDR_W'(COLS * ROWS - 1);
    localparam logic [6:0]        COL_MAX    = 7'(COLS - 1);
    localparam logic [5:0]        ROW_MAX    = 6'(ROWS - 1);
    localparam logic [1:0]        DIG_LAST   = 2'(LEN_DIGITS - 1);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DIGITS, S_CLEAR} state_t;
    typedef enum logic [1:0] {P_NORM, P_ESC, P_CSI} parse_t;

    state_t state, state_d;
    parse_t pstate, pstate_d;

    // rx_valid/rx_ready: a byte is taken on any clock where rx_valid is high and the FIFO
    // has room (or its head is popped that same clock); otherwise it is dropped and ovf sticks.
    logic [7:0] fifo_mem [FIFO_DEPTH];
    logic [FA:0] wptr, rptr;
    logic fifo_empty, fifo_full, push, pop;
    logic [7:0] head;

    assign fifo_empty = (wptr == rptr);
    assign fifo_full  = (wptr[FA] != rptr[FA]) && (wptr[FA-1:0] == rptr[FA-1:0]);
    assign pop        = (state == S_IDLE) && !fifo_empty;
    assign push       = rx_valid && (!fifo_full || pop);
    assign rx_ready   = !fifo_full;
    assign head       = fifo_mem[rptr[FA-1:0]];

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wptr[FA-1:0]] <= rx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            ovf  <= 1'b0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (rx_valid && !push) ovf <= 1'b1;
        end
    end

    logic [6:0]        cx, cx_d;
    logic [5:0]        cy, cy_d;
    logic [7:0]        p, p_d, byte_q, byte_d;
    logic [1:0]        dig, dig_d;
    logic [ADDR_W-1:0] clr_addr, clr_d;
    logic [6:0]        line_len, line_len_d;
    logic [6:0]        len_mem [ROWS];
    logic              wr_en_d, len_we, len_clear;
    logic [ADDR_W-1:0] wr_addr_d, row_base, cur_addr;
    logic [7:0]        wr_data_d;
    logic [11:0]       p_acc;
    logic [6:0]        cx_inc, cx_dec, cx_adv;
    logic [5:0]        cy_inc, cy_dec, cy_adv;

    assign row_base = ADDR_W'(cy) * COLS_A;
    assign cur_addr = row_base + ADDR_W'(cx);
    assign cursor   = cur_addr;
    assign cur_len  = len_mem[cy];
    assign busy     = (state != S_IDLE) || !fifo_empty;

    assign cx_inc = (cx == COL_MAX) ? 7'd0 : cx + 7'd1;
    assign cx_dec = (cx == 7'd0) ? COL_MAX : cx - 7'd1;
    assign cy_inc = (cy == ROW_MAX) ? 6'd0 : cy + 6'd1;
    assign cy_dec = (cy == 6'd0) ? ROW_MAX : cy - 6'd1;
    assign cx_adv = cx_inc;
    assign cy_adv = (WRAP_MODE != 0 && cx == COL_MAX) ? cy_inc : cy;
    assign p_acc  = {4'd0, p} * 12'd10 + {8'd0, head[3:0]};

    // Digit i of the length, blank when the length has fewer than i+1 digits.
    function automatic logic [7:0] digit_char(input logic [6:0] l, input logic [1:0] i);
        logic [6:0] q, pw, d;
        case (i)
            2'd0:    begin q = l;          pw = 7'd1;   end
            2'd1:    begin q = l / 7'd10;  pw = 7'd10;  end
            default: begin q = l / 7'd100; pw = 7'd100; end
        endcase
        d = q % 7'd10;
        return (l < pw) ? 8'h20 : 8'h30 + {1'b0, d};
    endfunction

    always_comb begin
        state_d    = state;
        pstate_d   = pstate;
        cx_d       = cx;
        cy_d       = cy;
        p_d        = p;
        byte_d     = byte_q;
        dig_d      = dig;
        clr_d      = clr_addr;
        line_len_d = line_len;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr;
        wr_data_d  = wr_data;
        len_we     = 1'b0;
        len_clear  = 1'b0;
        case (state)
            S_IDLE: if (!fifo_empty) begin
                case (pstate)
                    P_NORM: begin
                        if (head >= 8'h20 && head <= 8'h7E) begin
                            byte_d  = head;
                            state_d = S_WRITE;
                        end else begin
                            case (head)
                                8'h0D:   cx_d = 7'd0;
                                8'h0A:   cy_d = cy_inc;
                                8'h08:   if (cx != 7'd0) cx_d = cx - 7'd1;
                                8'h1B:   pstate_d = P_ESC;
                                default: ;
                            endcase
                        end
                    end
                    P_ESC: begin
                        if (head == 8'h5B) begin
                            pstate_d = P_CSI;
                            p_d      = 8'd0;
                        end else begin
                            pstate_d = P_NORM;
                        end
                    end
                    P_CSI: begin
                        if (head >= 8'h30 && head <= 8'h39) begin
                            p_d = (p_acc > 12'd255) ? 8'hFF : p_acc[7:0];
                        end else begin
                            pstate_d = P_NORM;
                            case (head)
                                8'h41:   cy_d = cy_dec;
                                8'h42:   cy_d = cy_inc;
                                8'h43:   cx_d = cx_inc;
                                8'h44:   cx_d = cx_dec;
                                8'h48:   begin cx_d = 7'd0; cy_d = 6'd0; end
                                8'h4A:   if (p == 8'd2) begin state_d = S_CLEAR; clr_d = '0; end
                                default: ;
                            endcase
                        end
                    end
                    default: pstate_d = P_NORM;
                endcase
            end
            S_WRITE: begin
                wr_en_d    = 1'b1;
                wr_addr_d  = cur_addr;
                wr_data_d  = byte_q;
                len_we     = 1'b1;
                line_len_d = (cx + 7'd1 > len_mem[cy]) ? cx + 7'd1 : len_mem[cy];
                if (SHOW_LEN != 0) begin
                    state_d = S_DIGITS;
                    dig_d   = 2'd0;
                end else begin
                    cx_d    = cx_adv;
                    cy_d    = cy_adv;
                    state_d = S_IDLE;
                end
            end
            S_DIGITS: begin
                wr_en_d   = 1'b1;
                wr_addr_d = row_base + COLS_A - ADDR_W'(1) - ADDR_W'(dig);
                wr_data_d = digit_char(line_len, dig);
                if (dig == DIG_LAST) begin
                    cx_d    = cx_adv;
                    cy_d    = cy_adv;
                    state_d = S_IDLE;
                end else begin
                    dig_d = dig + 2'd1;
                end
            end
            S_CLEAR: begin
                wr_en_d   = 1'b1;
                wr_addr_d = clr_addr;
                wr_data_d = 8'h20;
                clr_d     = clr_addr + ADDR_W'(1);
                if (clr_addr == CELLS_LAST) begin
                    cx_d      = 7'd0;
                    cy_d      = 6'd0;
                    len_clear = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            pstate   <= P_NORM;
            cx       <= 7'd0;
            cy       <= 6'd0;
            p        <= 8'd0;
            byte_q   <= 8'd0;
            dig      <= 2'd0;
            clr_addr <= '0;
            line_len <= 7'd0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= 8'd0;
            for (int r = 0; r < ROWS; r++) len_mem[r] <= 7'd0;
        end else begin
            state    <= state_d;
            pstate   <= pstate_d;
            cx       <= cx_d;
            cy       <= cy_d;
            p        <= p_d;
            byte_q   <= byte_d;
            dig      <= dig_d;
            clr_addr <= clr_d;
            line_len <= line_len_d;
            wr_en    <= wr_en_d;
            wr_addr  <= wr_addr_d;
            wr_data  <= wr_data_d;
            if (len_clear) begin
                for (int r = 0; r < ROWS; r++) len_mem[r] <= 7'd0;
            end else if (len_we) begin
                len_mem[cy] <= line_len_d;
            end
        end
    end
endmodule

// File: tb/tb_term_ctrl.sv
// Bench for term_ctrl: random byte streams against a cell-level terminal model, plus
// directed cases for latency, escape handling, wrap modes, clear, overflow and reset.
module tb_term_ctrl;
    localparam int COLS = 80;
    localparam int ROWS = 60;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_valid, rx_valid2;
    logic [7:0]  rx_data, rx_data2;
    logic        rx_ready, rx_ready2;
    logic        wr_en, wr_en2;
    logic [12:0] wr_addr, wr_addr2;
    logic [7:0]  wr_data, wr_data2;
    logic [12:0] cursor, cursor2;
    logic [6:0]  cur_len, cur_len2;
    logic        busy, busy2;
    logic        ovf, ovf2;

    term_ctrl dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cursor(cursor), .cur_len(cur_len), .busy(busy), .ovf(ovf)
    );

    term_ctrl #(.WRAP_MODE(1), .SHOW_LEN(0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid2), .rx_data(rx_data2),
        .rx_ready(rx_ready2), .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
        .cursor(cursor2), .cur_len(cur_len2), .busy(busy2), .ovf(ovf2)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int wr_count = 0;
    logic [20:0] exp_q[$];

    // Terminal model: cursor, parser mode and per-row lengths.
    int m_cx, m_cy, m_mode, m_p;
    int m_len[ROWS];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_cx = 0; m_cy = 0; m_mode = 0; m_p = 0;
        for (int r = 0; r < ROWS; r++) m_len[r] = 0;
    endtask

    task automatic model_print(input int b);
        int l, p10, ch;
        exp_q.push_back(21'((m_cy * COLS + m_cx) * 256 + b));
        if (m_cx + 1 > m_len[m_cy]) m_len[m_cy] = m_cx + 1;
        l = m_len[m_cy];
        for (int i = 0; i < 2; i++) begin
            p10 = (i == 0) ? 1 : 10;
            ch = (l < p10) ? 32 : 48 + (l / p10) % 10;
            exp_q.push_back(21'((m_cy * COLS + COLS - 1 - i) * 256 + ch));
        end
        m_cx = (m_cx + 1) % COLS;
    endtask

    task automatic model_clear();
        for (int a = 0; a < COLS * ROWS; a++) exp_q.push_back(21'(a * 256 + 32));
        m_cx = 0; m_cy = 0;
        for (int r = 0; r < ROWS; r++) m_len[r] = 0;
    endtask

    task automatic model_byte(input int b);
        case (m_mode)
            0: begin
                if (b >= 32 && b <= 126) model_print(b);
                else if (b == 13) m_cx = 0;
                else if (b == 10) m_cy = (m_cy + 1) % ROWS;
                else if (b == 8) begin if (m_cx > 0) m_cx--; end
                else if (b == 27) m_mode = 1;
            end
            1: begin
                if (b == 91) begin m_mode = 2; m_p = 0; end
                else m_mode = 0;
            end
            default: begin
                if (b >= 48 && b <= 57) begin
                    m_p = m_p * 10 + (b - 48);
                    if (m_p > 255) m_p = 255;
                end else begin
                    m_mode = 0;
                    case (b)
                        65: m_cy = (m_cy + ROWS - 1) % ROWS;
                        66: m_cy = (m_cy + 1) % ROWS;
                        67: m_cx = (m_cx + 1) % COLS;
                        68: m_cx = (m_cx + COLS - 1) % COLS;
                        72: begin m_cx = 0; m_cy = 0; end
                        74: if (m_p == 2) model_clear();
                        default: ;
                    endcase
                end
            end
        endcase
    endtask

    // Monitor: every buffer write must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got addr %0d data 0x%0h, none expected", wr_addr, wr_data);
            end else begin
                check("write", int'({wr_addr, wr_data}), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        while (!rx_ready && n < 20000) begin @(posedge clk); #1; n++; end
        if (!rx_ready) begin
            checks++;
            failures++;
            $display("FAIL rx_ready_timeout: got 0 expected 1");
            return;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        model_byte(int'(b));
    endtask

    task automatic send_byte2(input logic [7:0] b);
        rx_valid2 = 1'b1;
        rx_data2  = b;
        @(posedge clk); #1;
        rx_valid2 = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || wr_en) && n < 20000) begin @(posedge clk); #1; n++; end
        checks++;
        if (busy || wr_en) begin
            failures++;
            $display("FAIL idle_timeout: got busy expected idle");
        end
    endtask

    task automatic check_cursor();
        check("cursor", int'(cursor), m_cy * COLS + m_cx);
        check("cur_len", int'(cur_len), m_len[m_cy]);
    endtask

    logic [7:0] finals[8] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h48, 8'h4A, 8'h6D, 8'h3B};
    logic [7:0] wrap_seq[7] = '{8'h1B, 8'h5B, 8'h44, 8'h1B, 8'h5B, 8'h41, 8'h7A};

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, wc0, kind, nd;
        rst_n = 1'b0;
        rx_valid = 1'b0; rx_data = 8'h00;
        rx_valid2 = 1'b0; rx_data2 = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_wr_en", int'(wr_en), 0);
        check("rst_wr_addr", int'(wr_addr), 0);
        check("rst_wr_data", int'(wr_data), 0);
        check("rst_cursor", int'(cursor), 0);
        check("rst_cur_len", int'(cur_len), 0);
        check("rst_rx_ready", int'(rx_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_ovf", int'(ovf), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Push 'A' and check first-write latency and the digit writes.
        rx_valid = 1'b1; rx_data = 8'h41;
        model_byte(8'h41);
        @(posedge clk); #1;
        rx_valid = 1'b0;
        @(posedge clk); #1;
        check("lat_early", int'(wr_en), 0);
        @(posedge clk); #1;
        check("lat_wr_en", int'(wr_en), 1);
        check("lat_addr", int'(wr_addr), 0);
        check("lat_data", int'(wr_data), 8'h41);
        @(posedge clk); #1;
        check("dig0_addr", int'(wr_addr), 79);
        check("dig0_data", int'(wr_data), 8'h31);
        @(posedge clk); #1;
        check("dig1_addr", int'(wr_addr), 78);
        check("dig1_data", int'(wr_data), 8'h20);
        wait_idle();
        check_cursor();
        check("a_cursor", int'(cursor), 1);

        // Arrows wrap without writes; a bare ESC swallows the next byte.
        send_byte(8'h0D);
        send_byte(8'h1B); send_byte(8'h5B); send_byte(8'h44);
        wait_idle();
        check("left_wrap", int'(cursor), 79);
        send_byte(8'h1B); send_byte(8'h5B); send_byte(8'h41);
        wait_idle();
        check("up_wrap", int'(cursor), 4799);
        send_byte(8'h1B); send_byte(8'h58); send_byte(8'h42);
        wait_idle();
        check("wrap0_cursor", int'(cursor), 4720);
        check_cursor();

        // Same corner on the row-wrapping instance.
        foreach (wrap_seq[i]) send_byte2(wrap_seq[i]);
        n = 0;
        while (!wr_en2 && n < 50) begin @(posedge clk); #1; n++; end
        check("wrap1_wr_en", int'(wr_en2), 1);
        check("wrap1_addr", int'(wr_addr2), 4799);
        check("wrap1_data", int'(wr_data2), 8'h7A);
        n = 0;
        while ((busy2 || wr_en2) && n < 50) begin @(posedge clk); #1; n++; end
        check("wrap1_cursor", int'(cursor2), 0);

        // Random byte stream.
        for (int t = 0; t < 250; t++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 4) send_byte(8'($urandom_range(32, 126)));
            else if (kind == 5) send_byte(finals[0] == 8'h41 ? 8'($urandom_range(0, 2) == 0 ? 13 : ($urandom_range(0, 1) == 0 ? 10 : 8)) : 8'd13);
            else if (kind == 6) begin
                send_byte(8'h1B); send_byte(8'h5B);
                send_byte(finals[$urandom_range(0, 4)]);
            end else if (kind == 7) begin
                send_byte(8'h1B); send_byte(8'($urandom_range(0, 255)));
            end else if (kind == 8) begin
                send_byte(8'h1B); send_byte(8'h5B);
                nd = $urandom_range(0, 3);
                for (int d = 0; d < nd; d++) send_byte(8'($urandom_range(48, 57)));
                send_byte(finals[$urandom_range(0, 7)]);
            end else send_byte(8'($urandom_range(0, 255)));
            if (t % 25 == 24) begin
                wait_idle();
                check_cursor();
            end
        end
        wait_idle();
        check_cursor();

        // Clear screen: rows 1..3 get non-zero lengths first.
        send_byte(8'h1B); send_byte(8'h5B); send_byte(8'h48);
        for (int r = 0; r < 3; r++) begin send_byte(8'h0A); send_byte(8'h78); end
        wait_idle();
        check("pre_clear_len", int'(cur_len), m_len[3]);
        wc0 = wr_count;
        send_byte(8'h1B); send_byte(8'h5B); send_byte(8'h32); send_byte(8'h4A);
        wait_idle();
        check("clear_writes", wr_count - wc0, 4800);
        check_cursor();
        for (int r = 0; r < 3; r++) begin
            send_byte(8'h1B); send_byte(8'h5B); send_byte(8'h42);
            wait_idle();
            check("row_len_cleared", int'(cur_len), 0);
        end

        // Overflow during clear: six back-to-back bytes, only four fit.
        send_byte(8'h1B); send_byte(8'h5B); send_byte(8'h32); send_byte(8'h4A);
        n = 0;
        while (!wr_en && n < 50) begin @(posedge clk); #1; n++; end
        check("clear_started", int'(wr_en), 1);
        for (int i = 0; i < 6; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'h61 + 8'(i);
            @(posedge clk); #1;
            if (i == 3) check("ovf_rx_ready", int'(rx_ready), 0);
            if (i < 4) model_byte(8'h61 + i);
        end
        rx_valid = 1'b0;
        check("ovf_flag", int'(ovf), 1);
        wait_idle();
        check_cursor();
        check("ovf_ovf_sticky", int'(ovf), 1);

        // Reset in the middle of a clear.
        send_byte(8'h1B); send_byte(8'h5B); send_byte(8'h32); send_byte(8'h4A);
        repeat (100) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_wr_en", int'(wr_en), 0);
        check("mid_rst_cursor", int'(cursor), 0);
        check("mid_rst_rx_ready", int'(rx_ready), 1);
        check("mid_rst_ovf", int'(ovf), 0);
        check("mid_rst_cur_len", int'(cur_len), 0);
        exp_q.delete();
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        send_byte(8'h51);
        wait_idle();
        check_cursor();
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
